// File: rtl/gpu_pkg.sv
// Shared GPU types: coordinates, colours, frame defaults and the rect-fill state encoding.
package gpu_pkg;

    typedef logic [9:0] coord_t;
    typedef logic [3:0] color_t;

    localparam int FB_WIDTH_DEF  = 640;
    localparam int FB_HEIGHT_DEF = 480;

    typedef enum logic [1:0] {
        RF_IDLE = 2'd0,
        RF_FILL = 2'd1,
        RF_DONE = 2'd2
    } rf_state_t;

    // Saturate a coordinate to lim when en is set; pass through otherwise.
    function automatic coord_t clamp_coord(input coord_t v, input coord_t lim, input logic en);
        return (en && (v > lim)) ? lim : v;
    endfunction

endpackage

// File: rtl/raster_scan_counter.sv
// Raster walker over an inclusive box: loads at (x0,y0), steps x then y, flags the (x1,y1) corner.
module raster_scan_counter
    import gpu_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   step,
    input  coord_t x0,
    input  coord_t y0,
    input  coord_t x1,
    input  coord_t y1,
    output coord_t x,
    output coord_t y,
    output logic   last
);

    coord_t x0_r;
    coord_t x1_r;
    coord_t y1_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (load) begin
            x <= x0;
            y <= y0;
        end else if (step) begin
            if (x == x1_r) begin
                x <= x0_r;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    // Box bounds are pure data and only meaningful after a load.
    always_ff @(posedge clk) begin
        if (load) begin
            x0_r <= x0;
            x1_r <= x1;
            y1_r <= y1;
        end
    end

    assign last = (x == x1_r) && (y == y1_r);

endmodule

// File: rtl/rect_fill_unit.sv
// Solid rectangle fill streaming one pixel per clock to the frame-buffer write port.
// Optional build macro RECT_FILL_CLIP_EN clamps the far corner to the visible frame.
module rect_fill_unit
    import gpu_pkg::*;
#(
    parameter int FB_WIDTH  = FB_WIDTH_DEF,
    parameter int FB_HEIGHT = FB_HEIGHT_DEF
) (
    input  logic   clk,
    input  logic   areset,
    input  logic   start,
    input  coord_t x0,
    input  coord_t y0,
    input  coord_t x1,
    input  coord_t y1,
    input  color_t color,
    output logic   busy,
    output logic   done,
    output coord_t fb_x,
    output coord_t fb_y,
    output color_t data,
    output logic   fb_we
);

`ifdef RECT_FILL_CLIP_EN
    localparam logic CLIP_ON = 1'b1;
`else
    localparam logic CLIP_ON = 1'b0;
`endif
    localparam coord_t X_LIM = coord_t'(FB_WIDTH - 1);
    localparam coord_t Y_LIM = coord_t'(FB_HEIGHT - 1);

    rf_state_t state;
    coord_t    x1_c;
    coord_t    y1_c;
    logic      empty;
    logic      last;
    logic      load;
    logic      step;

    // A clamped far corner already falls below x0/y0 when the origin lies off-frame.
    always_comb begin
        x1_c  = clamp_coord(x1, X_LIM, CLIP_ON);
        y1_c  = clamp_coord(y1, Y_LIM, CLIP_ON);
        empty = (x0 > x1_c) || (y0 > y1_c);
    end

    assign load = (state == RF_IDLE) && start && !empty;
    assign step = (state == RF_FILL) && !last;

    raster_scan_counter u_scan (
        .clk  (clk),
        .rst  (areset),
        .load (load),
        .step (step),
        .x0   (x0),
        .y0   (y0),
        .x1   (x1_c),
        .y1   (y1_c),
        .x    (fb_x),
        .y    (fb_y),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (areset) begin
            state <= RF_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            fb_we <= 1'b0;
            data  <= '0;
        end else begin
            case (state)
                RF_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (empty) begin
                            state <= RF_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RF_FILL;
                            fb_we <= 1'b1;
                            data  <= color;
                        end
                    end
                end
                RF_FILL: begin
                    if (last) begin
                        state <= RF_DONE;
                        fb_we <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                RF_DONE: begin
                    state <= RF_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= RF_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    fb_we <= 1'b0;
                end
            endcase
        end
    end

endmodule
